mm_seq: RTL and testbench
=========================

# mm_seq

Matrix-matrix job sequencer that drives `mv_mul` from the initiator side and collects its results. It accepts one job: an `SHAPE_M x SHAPE_N` matrix A and `SHAPE_K` column vectors of B. It holds A on the `mv_mul` operand port and issues the B columns one per handshake. It reassembles the `SHAPE_K` returned `SHAPE_M`-element result vectors into the C matrix and presents C with OR-accumulated fflags and the job's writeback metadata.

## Interface
Parameters:
- `SHAPE_M`, default 8: rows of A; elements per `mv_mul` result.
- `SHAPE_N`, default 8: columns of A; elements per B column.
- `SHAPE_K`, default 8: number of B columns, i.e. `mv_mul` issues per job (≥1).
- `ELEMENT_WIDTH`, default 9: bits per element.
- `DEPTH_WARP`, default 4: warp id width.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `job_valid_i`  in  1  job offered.
- `job_ready_o`  out  1  sequencer idle, job accepted on `valid & ready`.
- `job_a_i`  in  `SHAPE_M*SHAPE_N*ELEMENT_WIDTH`  A; row r at slice `[(r+1)*N*EW-1 -: N*EW]`.
- `job_b_i`  in  `SHAPE_K*SHAPE_N*ELEMENT_WIDTH`  B; column k at slice `[(k+1)*N*EW-1 -: N*EW]`.
- `job_reg_idxw_i`  in  8  destination register index.
- `job_warpid_i`  in  `DEPTH_WARP`  warp id.
- `mv_a_o`  out  `SHAPE_M*SHAPE_N*ELEMENT_WIDTH`  to `mv_mul.a_i`.
- `mv_b_o`  out  `SHAPE_N*ELEMENT_WIDTH`  to `mv_mul.b_i`.
- `mv_valid_o`  out  1  to `mv_mul.in_valid_i`.
- `mv_ready_i`  in  1  from `mv_mul.in_ready_o`.
- `mv_result_i`  in  `SHAPE_M*ELEMENT_WIDTH`  from `mv_mul.result_o`.
- `mv_fflags_i`  in  5  from `mv_mul.fflags_o`.
- `mv_out_valid_i`  in  1  from `mv_mul.out_valid_o`.
- `mv_out_ready_o`  out  1  to `mv_mul.out_ready_i`.
- `res_valid_o`  out  1  C available.
- `res_ready_i`  in  1  consumer accepts C.
- `res_c_o`  out  `SHAPE_K*SHAPE_M*ELEMENT_WIDTH`  C; column k at slice `[(k+1)*M*EW-1 -: M*EW]`.
- `res_fflags_o`  out  5  OR of all K returned fflags.
- `res_reg_idxw_o`  out  8  latched `job_reg_idxw_i`.
- `res_warpid_o`  out  `DEPTH_WARP`  latched `job_warpid_i`.

## Operation
- FSM states and transitions:
  - IDLE: `job_ready_o=1`. On job handshake, latch A, B, reg_idxw and warpid, clear `issue_cnt`, `ret_cnt` and the fflags accumulator, then go to RUN.
  - RUN: `mv_valid_o = (issue_cnt < SHAPE_K)`. `mv_b_o` = B column `issue_cnt`; `mv_a_o` = latched A. `issue_cnt` increments on `mv_valid_o & mv_ready_i`.
  - RUN, result side: `mv_out_ready_o=1`. On `mv_out_valid_i`, write `mv_result_i` into C column `ret_cnt`, OR `mv_fflags_i` into the accumulator, and increment `ret_cnt`. When `ret_cnt==SHAPE_K-1` on a handshake, go to DONE.
  - DONE: `res_valid_o=1`; C and metadata are held. On `res_ready_i`, go to IDLE.
- Results return in issue order; column index comes from `ret_cnt`, with no tagging.
- Issue and return handshakes in the same cycle are both honoured.
- `mv_mul` operands stay stable while `mv_valid_o & !mv_ready_i`.
- `mv_out_ready_o=0` and `mv_valid_o=0` outside RUN.
- Counter width is `$clog2(SHAPE_K+1)`. Counters never wrap: issue stops at K and the state exits at K returns.

## Timing
- Reset (async assert, sync release): state IDLE. Outputs are 0 except `job_ready_o=1`. This covers `mv_valid_o`, `mv_out_ready_o`, `res_valid_o`, `res_c_o`, `res_fflags_o`, `res_*` metadata, `mv_a_o` and `mv_b_o`.
- Reset mid-job aborts the job with no result output. In-flight `mv_mul` results are discarded, since `mv_mul` shares `rst_n`.
- Job accepted at cycle 0 → `mv_valid_o=1` at cycle 1.
- With `mv_ready_i` held high, issues occur at cycles 1..K.
- Last return handshake at cycle t → `res_valid_o=1` at t+1.
- No IDLE bypass: the next job can be accepted no earlier than the cycle after the `res` handshake.

## Structure
- Package `mm_seq_pkg`: state enum (`IDLE`, `RUN`, `DONE`) and a count-width function/localparam.
- Sub-module `mm_col_buf`: K-column result register bank with write-enable, write index and clear, exposing the flattened C.

## Test plan
- **Basic job.** K=8, `mv_ready_i`=1, and a behavioural `mv_mul` model that returns all lanes = k+1 for issue k after 3 cycles. Required: C column k all elements = k+1; `res_valid_o` at cycle 12 (last return at 11); `mv_b_o` at issue k equals B column k.
- **Issue backpressure.** `mv_ready_i` toggles 1,0,0,1. Required: `mv_b_o`/`mv_a_o` stable during stalls; exactly 8 issues; no duplicated or skipped columns.
- **Sparse returns.** Returns arrive with random 0–5 cycle gaps, and some arrive in the same cycle as an issue. Required: C correct; `ret_cnt` ends at 8.
- **Result stall.** `res_ready_i`=0 for 10 cycles. Required: `res_valid_o` and C held, `job_ready_o=0`. After `res_ready_i`=1, IDLE next cycle with `job_ready_o=1`.
- **Fflags accumulation.** Issue 2 returns fflags 5'b00001 and issue 5 returns 5'b10000. Required: `res_fflags_o=5'b10001`; the next job starts at 0.
- **Reset mid-RUN.** `rst_n` low after 3 issues. Required: all outputs at reset values immediately, no `res_valid_o`; a new job afterwards completes correctly.

Source files
------------

// File: rtl/mm_seq_pkg.sv
// mm_seq_pkg: state encoding and counter sizing shared by the mm_seq job sequencer.
package mm_seq_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic int cnt_w(input int k);
        return $clog2(k + 1);
    endfunction
endpackage

// File: rtl/mm_col_buf.sv
// mm_col_buf: K-column result register bank; one M-element column written per cycle by index.
module mm_col_buf
    import mm_seq_pkg::*;
#(
    parameter int SHAPE_K       = 8,
    parameter int SHAPE_M       = 8,
    parameter int ELEMENT_WIDTH = 9,
    parameter int CW            = cnt_w(SHAPE_K)
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     clr,
    input  logic                                     we,
    input  logic [CW-1:0]                            idx,
    input  logic [SHAPE_M*ELEMENT_WIDTH-1:0]         din,
    output logic [SHAPE_K*SHAPE_M*ELEMENT_WIDTH-1:0] c
);
    localparam int COL = SHAPE_M * ELEMENT_WIDTH;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            c <= '0;
        else if (clr)
            c <= '0;
        else if (we)
            for (int k = 0; k < SHAPE_K; k++)
                if (idx == CW'(k)) c[k*COL +: COL] <= din;
endmodule

// File: rtl/mm_seq.sv
// mm_seq: drives mv_mul with a held A and K successive B columns, reassembling the K result
// vectors into C with OR-accumulated fflags and the job's writeback metadata.
module mm_seq
    import mm_seq_pkg::*;
#(
    parameter int SHAPE_M       = 8,
    parameter int SHAPE_N       = 8,
    parameter int SHAPE_K       = 8,
    parameter int ELEMENT_WIDTH = 9,
    parameter int DEPTH_WARP    = 4
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     job_valid_i,
    output logic                                     job_ready_o,
    input  logic [SHAPE_M*SHAPE_N*ELEMENT_WIDTH-1:0] job_a_i,
    input  logic [SHAPE_K*SHAPE_N*ELEMENT_WIDTH-1:0] job_b_i,
    input  logic [7:0]                               job_reg_idxw_i,
    input  logic [DEPTH_WARP-1:0]                    job_warpid_i,
    output logic [SHAPE_M*SHAPE_N*ELEMENT_WIDTH-1:0] mv_a_o,
    output logic [SHAPE_N*ELEMENT_WIDTH-1:0]         mv_b_o,
    output logic                                     mv_valid_o,
    input  logic                                     mv_ready_i,
    input  logic [SHAPE_M*ELEMENT_WIDTH-1:0]         mv_result_i,
    input  logic [4:0]                               mv_fflags_i,
    input  logic                                     mv_out_valid_i,
    output logic                                     mv_out_ready_o,
    output logic                                     res_valid_o,
    input  logic                                     res_ready_i,
    output logic [SHAPE_K*SHAPE_M*ELEMENT_WIDTH-1:0] res_c_o,
    output logic [4:0]                               res_fflags_o,
    output logic [7:0]                               res_reg_idxw_o,
    output logic [DEPTH_WARP-1:0]                    res_warpid_o
);
    localparam int CW    = cnt_w(SHAPE_K);
    localparam int COL_B = SHAPE_N * ELEMENT_WIDTH;

    state_t                       state;
    logic [SHAPE_K*COL_B-1:0]     b_q;
    logic [CW-1:0]                issue_cnt;
    logic [CW-1:0]                ret_cnt;
    logic                         accept;
    logic                         ret_hs;

    assign job_ready_o    = state == IDLE;
    assign accept         = job_valid_i && job_ready_o;
    assign mv_valid_o     = state == RUN && issue_cnt < CW'(SHAPE_K);
    assign mv_out_ready_o = state == RUN;
    assign ret_hs         = mv_out_valid_i && mv_out_ready_o;
    assign res_valid_o    = state == DONE;

    // issue_cnt parks at K once all columns are out, which selects no column
    always_comb begin
        mv_b_o = '0;
        for (int k = 0; k < SHAPE_K; k++)
            if (issue_cnt == CW'(k)) mv_b_o = b_q[k*COL_B +: COL_B];
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state          <= IDLE;
            mv_a_o         <= '0;
            b_q            <= '0;
            issue_cnt      <= '0;
            ret_cnt        <= '0;
            res_fflags_o   <= '0;
            res_reg_idxw_o <= '0;
            res_warpid_o   <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    mv_a_o         <= job_a_i;
                    b_q            <= job_b_i;
                    res_reg_idxw_o <= job_reg_idxw_i;
                    res_warpid_o   <= job_warpid_i;
                    issue_cnt      <= '0;
                    ret_cnt        <= '0;
                    res_fflags_o   <= '0;
                    state          <= RUN;
                end
                RUN: begin
                    if (mv_valid_o && mv_ready_i) issue_cnt <= issue_cnt + 1'b1;
                    if (ret_hs) begin
                        res_fflags_o <= res_fflags_o | mv_fflags_i;
                        ret_cnt      <= ret_cnt + 1'b1;
                        if (ret_cnt == CW'(SHAPE_K - 1)) state <= DONE;
                    end
                end
                DONE: if (res_ready_i) state <= IDLE;
                default: state <= IDLE;
            endcase
        end

    mm_col_buf #(
        .SHAPE_K      (SHAPE_K),
        .SHAPE_M      (SHAPE_M),
        .ELEMENT_WIDTH(ELEMENT_WIDTH),
        .CW           (CW)
    ) u_col_buf (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (accept),
        .we   (ret_hs),
        .idx  (ret_cnt),
        .din  (mv_result_i),
        .c    (res_c_o)
    );
endmodule

// File: tb/tb_mm_seq.sv
// tb_mm_seq: directed jobs against a behavioural mv_mul whose result lanes echo element 0
// of the issued B column, with issue and result scoreboards.
module tb_mm_seq;
    localparam int M = 8, N = 8, K = 8, EW = 9, DW = 4;
    localparam int AW = M*N*EW, BW = K*N*EW, CWD = K*M*EW, NEW = N*EW, MEW = M*EW;

    logic            clk = 0, rst_n = 1;
    logic            job_valid_i = 0, job_ready_o;
    logic [AW-1:0]   job_a_i = '0;
    logic [BW-1:0]   job_b_i = '0;
    logic [7:0]      job_reg_idxw_i = '0;
    logic [DW-1:0]   job_warpid_i = '0;
    logic [AW-1:0]   mv_a_o;
    logic [NEW-1:0]  mv_b_o;
    logic            mv_valid_o, mv_ready_i = 0;
    logic [MEW-1:0]  mv_result_i = '0;
    logic [4:0]      mv_fflags_i = '0;
    logic            mv_out_valid_i = 0, mv_out_ready_o;
    logic            res_valid_o, res_ready_i = 0;
    logic [CWD-1:0]  res_c_o;
    logic [4:0]      res_fflags_o;
    logic [7:0]      res_reg_idxw_o;
    logic [DW-1:0]   res_warpid_o;

    typedef struct {logic [CWD-1:0] c; logic [4:0] ff; logic [7:0] ri; logic [DW-1:0] wi;} res_t;
    typedef struct {int due; logic [EW-1:0] val; logic [4:0] ff;} ret_t;

    res_t            sb[$];
    logic [NEW-1:0]  exp_b[$];
    ret_t            pend[$];
    logic [AW-1:0]   exp_a;
    logic [4:0]      ff_tab[K];
    logic [3:0]      rdy_pat = 4'b1111;
    bit              rand_gap = 0;
    int              n_iss = 0, cyc = 0, c0 = 0, last_due = 0, checks = 0, failures = 0;

    mm_seq #(.SHAPE_M(M), .SHAPE_N(N), .SHAPE_K(K), .ELEMENT_WIDTH(EW), .DEPTH_WARP(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .job_valid_i(job_valid_i), .job_ready_o(job_ready_o),
        .job_a_i(job_a_i), .job_b_i(job_b_i),
        .job_reg_idxw_i(job_reg_idxw_i), .job_warpid_i(job_warpid_i),
        .mv_a_o(mv_a_o), .mv_b_o(mv_b_o), .mv_valid_o(mv_valid_o), .mv_ready_i(mv_ready_i),
        .mv_result_i(mv_result_i), .mv_fflags_i(mv_fflags_i),
        .mv_out_valid_i(mv_out_valid_i), .mv_out_ready_o(mv_out_ready_o),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_c_o(res_c_o),
        .res_fflags_o(res_fflags_o), .res_reg_idxw_o(res_reg_idxw_o), .res_warpid_o(res_warpid_o)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [CWD-1:0] obs, input logic [CWD-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mv_mul stand-in: stimulus driven on negedge, handshakes complete at the next posedge
    initial begin
        logic         stalled;
        logic [NEW-1:0] held_b;
        logic [AW-1:0]  held_a;
        ret_t         r;
        stalled = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend.delete();
                mv_out_valid_i = 0;
                n_iss = 0;
                stalled = 0;
                continue;
            end
            mv_ready_i = rdy_pat[cyc % 4];
            if (stalled) begin
                chk("stall_b_stable", mv_b_o, held_b);
                chk("stall_a_stable", mv_a_o, held_a);
            end
            stalled = mv_valid_o && !mv_ready_i;
            held_b  = mv_b_o;
            held_a  = mv_a_o;
            if (mv_valid_o && mv_ready_i) begin
                if (exp_b.size() == 0) chk("extra_issue", 1'b1, 1'b0);
                else chk("issue_b", mv_b_o, exp_b.pop_front());
                chk("issue_a", mv_a_o, exp_a);
                r.due = rand_gap ? ((cyc + 1 > last_due) ? cyc + 1 : last_due) + int'($urandom_range(0, 5))
                                 : cyc + 3;
                r.val = mv_b_o[EW-1:0];
                r.ff  = (n_iss < K) ? ff_tab[n_iss] : 5'b0;
                pend.push_back(r);
                last_due = r.due;
                n_iss++;
            end
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                mv_out_valid_i = 1;
                mv_result_i    = {M{pend[0].val}};
                mv_fflags_i    = pend[0].ff;
                if (mv_out_ready_o) void'(pend.pop_front());
            end else begin
                mv_out_valid_i = 0;
                mv_result_i    = '0;
                mv_fflags_i    = '0;
            end
        end
    end

    task automatic chk_reset(input string tag);
        chk({tag, "_job_ready"}, job_ready_o, 1'b1);
        chk({tag, "_mv_valid"}, mv_valid_o, 1'b0);
        chk({tag, "_mv_out_ready"}, mv_out_ready_o, 1'b0);
        chk({tag, "_res_valid"}, res_valid_o, 1'b0);
        chk({tag, "_res_c"}, res_c_o, '0);
        chk({tag, "_res_fflags"}, res_fflags_o, '0);
        chk({tag, "_res_reg"}, res_reg_idxw_o, '0);
        chk({tag, "_res_warp"}, res_warpid_o, '0);
        chk({tag, "_mv_a"}, mv_a_o, '0);
        chk({tag, "_mv_b"}, mv_b_o, '0);
    endtask

    task automatic rand_ab(output logic [AW-1:0] a, output logic [BW-1:0] b);
        for (int i = 0; i < AW; i += 32) a[i +: 32] = $urandom;
        for (int i = 0; i < BW; i += 32) b[i +: 32] = $urandom;
    endtask

    task automatic start_job(input logic [AW-1:0] a, input logic [BW-1:0] b,
                             input logic [7:0] ri, input logic [DW-1:0] wi);
        res_t e;
        e.ff = '0;
        for (int k = 0; k < K; k++) begin
            exp_b.push_back(b[k*NEW +: NEW]);
            for (int m = 0; m < M; m++) e.c[(k*M+m)*EW +: EW] = b[k*NEW +: EW];
            e.ff |= ff_tab[k];
        end
        e.ri = ri;
        e.wi = wi;
        sb.push_back(e);
        exp_a = a;
        n_iss = 0;
        @(negedge clk);
        job_valid_i = 1; job_a_i = a; job_b_i = b; job_reg_idxw_i = ri; job_warpid_i = wi;
        for (int i = 0; i < 50 && !job_ready_o; i++) @(negedge clk);
        chk("job_accept", job_ready_o, 1'b1);
        c0 = cyc;
        @(negedge clk);
        job_valid_i = 0;
        chk("valid_cycle1", mv_valid_o, 1'b1);
    endtask

    task automatic finish_job(input int exp_lat, input int hold);
        res_t e;
        logic [CWD-1:0] c_held;
        for (int i = 0; i < 400 && !res_valid_o; i++) @(negedge clk);
        chk("res_valid", res_valid_o, 1'b1);
        if (exp_lat >= 0) chk("res_latency", cyc - c0, exp_lat);
        if (sb.size() == 0) chk("sb_empty", 1'b1, 1'b0);
        else begin
            e = sb.pop_front();
            chk("res_c", res_c_o, e.c);
            chk("res_fflags", res_fflags_o, e.ff);
            chk("res_reg", res_reg_idxw_o, e.ri);
            chk("res_warp", res_warpid_o, e.wi);
        end
        chk("issue_count", n_iss, K);
        chk("issue_q_empty", exp_b.size(), 0);
        c_held = res_c_o;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", res_valid_o, 1'b1);
            chk("hold_job_ready", job_ready_o, 1'b0);
            chk("hold_c", res_c_o, c_held);
        end
        res_ready_i = 1;
        @(negedge clk);
        res_ready_i = 0;
        chk("idle_job_ready", job_ready_o, 1'b1);
        chk("idle_res_valid", res_valid_o, 1'b0);
    endtask

    initial begin
        logic [AW-1:0] a;
        logic [BW-1:0] b;
        for (int k = 0; k < K; k++) ff_tab[k] = '0;
        #1 rst_n = 0;
        #1 chk_reset("reset");
        repeat (2) @(negedge clk);
        rst_n = 1;

        // basic: column k carries k+1 in element 0, so C column k must be all k+1
        rand_ab(a, b);
        for (int k = 0; k < K; k++) b[k*NEW +: EW] = EW'(k + 1);
        start_job(a, b, 8'h11, 4'h3);
        finish_job(12, 0);
        chk("basic_col7", res_c_o[7*MEW +: EW], EW'(8));

        // issue backpressure
        rdy_pat = 4'b1001;
        rand_ab(a, b);
        start_job(a, b, 8'h22, 4'h5);
        finish_job(-1, 0);
        rdy_pat = 4'b1111;

        // sparse, randomly gapped returns
        rand_gap = 1;
        rand_ab(a, b);
        start_job(a, b, 8'h33, 4'h9);
        finish_job(-1, 0);
        rand_gap = 0;

        // result stall
        rand_ab(a, b);
        start_job(a, b, 8'hA4, 4'hC);
        finish_job(-1, 10);

        // fflags accumulation, then a clean job
        ff_tab[2] = 5'b00001;
        ff_tab[5] = 5'b10000;
        rand_ab(a, b);
        start_job(a, b, 8'h55, 4'h1);
        finish_job(-1, 0);
        chk("fflags_or", res_fflags_o, 5'b10001);
        ff_tab[2] = '0;
        ff_tab[5] = '0;
        rand_ab(a, b);
        start_job(a, b, 8'h66, 4'h2);
        finish_job(-1, 0);

        // reset mid-RUN after three issues
        rand_ab(a, b);
        start_job(a, b, 8'h77, 4'h7);
        for (int i = 0; i < 50 && n_iss < 3; i++) begin @(negedge clk); #1; end
        @(posedge clk);
        #2 rst_n = 0;
        #1 chk_reset("mid_reset");
        sb.delete();
        exp_b.delete();
        repeat (2) @(negedge clk);
        #1 rst_n = 1;
        chk("post_reset_res_valid", res_valid_o, 1'b0);
        rand_ab(a, b);
        start_job(a, b, 8'h88, 4'hE);
        finish_job(12, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
